// File: rtl/spi_cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_cmd_pkg
// Shared types and constants for the SPI command sequencer.
//   state_e     : sequencer FSM states (also exported for debug)
//   CMD_RD_BIT  : bit of the command byte that selects read (1) / write (0)
//   DUMMY_DEF   : default byte shifted out on MISO during write frames
//   ADDR_W_DEF  : default register address width
// ---------------------------------------------------------------------------
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WR     = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_CAP = 3'd4,
    ST_RD     = 3'd5
  } state_e;

  localparam int         CMD_RD_BIT = 7;
  localparam logic [7:0] DUMMY_DEF  = 8'h00;
  localparam int         ADDR_W_DEF = 7;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_ctrl_if
// Bundles the byte-engine side and register-file side of the sequencer.
//   Byte engine -> ctrl : frame_start, frame_end, rx_valid, rx_data, status
//   ctrl -> byte engine : tx_data, tx_load
//   ctrl -> reg file    : reg_addr, reg_wdata, reg_we, reg_re
//   reg file -> ctrl    : reg_rdata
//   ctrl status         : busy, overrun
// Modports: slave = the sequencer, master = its environment.
// ---------------------------------------------------------------------------
interface spi_cmd_ctrl_if
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              frame_start;
  logic              frame_end;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [7:0]        status;
  logic [7:0]        tx_data;
  logic              tx_load;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic              overrun;

  modport slave (
    input  frame_start, frame_end, rx_valid, rx_data, status, reg_rdata,
    output tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_re, busy, overrun
  );

  modport master (
    output frame_start, frame_end, rx_valid, rx_data, status, reg_rdata,
    input  tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_re, busy, overrun
  );

endinterface

// File: rtl/spi_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// spi_cmd_ctrl
// Command sequencer behind the SPI slave byte engine. The first byte of each
// SSEL frame is a command (bit7 = read, low bits = start address); later
// bytes become register writes, or dummy bytes that trigger read prefetches,
// with address auto-increment (wrapping modulo 2^ADDR_W).
// Ports:
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : spi_cmd_ctrl_if.slave (byte engine + register file signals)
//   state_o  : current FSM state, for debug/observation
//
// Handshake: there is no backpressure anywhere. frame_start, frame_end,
// rx_valid, tx_load, reg_we and reg_re are single-cycle pulses; a pulse is
// consumed on the clock edge that samples it. rx_data is meaningful only
// while rx_valid is high, reg_rdata only in the cycle after reg_re.
// Input priority: rst > frame_start > frame_end > rx_valid.
// ---------------------------------------------------------------------------
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter logic [7:0] DUMMY  = DUMMY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  spi_cmd_ctrl_if.slave   bus,
  output state_e          state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_load_q, tx_load_d;
  logic              overrun_q, overrun_d;
  logic              rd_load;

  // reg_rdata only becomes valid in RD_CAP, so the read byte is presented to
  // the byte engine combinationally in that cycle (tx_load exactly 2 clk
  // after rx_valid) and latched into tx_data_q for the following cycles.
  // A frame boundary in RD_CAP aborts the load.
  assign rd_load = (state_q == ST_RD_CAP) && !bus.frame_start && !bus.frame_end;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.frame_start) begin
      state_d = ST_CMD;
    end else if (bus.frame_end) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_CMD:    if (bus.rx_valid)
                     state_d = bus.rx_data[CMD_RD_BIT] ? ST_RD_REQ : ST_WR;
        ST_WR:     state_d = ST_WR;
        ST_RD_REQ: state_d = ST_RD_CAP;
        ST_RD_CAP: state_d = ST_RD;
        ST_RD:     if (bus.rx_valid) state_d = ST_RD_REQ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    overrun_d   = overrun_q;
    if (bus.frame_start) begin
      tx_data_d = bus.status;
      tx_load_d = 1'b1;
      overrun_d = 1'b0;
    end else begin
      // A byte arriving mid-fetch is dropped and flagged.
      if (bus.rx_valid && (state_q == ST_RD_REQ || state_q == ST_RD_CAP))
        overrun_d = 1'b1;
      unique case (state_q)
        ST_CMD: begin
          if (bus.rx_valid) begin
            addr_d = bus.rx_data[ADDR_W-1:0];
            if (bus.rx_data[CMD_RD_BIT]) begin
              reg_addr_d = bus.rx_data[ADDR_W-1:0];
            end else if (!bus.frame_end) begin
              tx_data_d = DUMMY;
              tx_load_d = 1'b1;
            end
          end
        end
        ST_WR: begin
          // The write commits even when frame_end coincides with the byte;
          // only the MISO reload is suppressed since the frame is over.
          if (bus.rx_valid) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = bus.rx_data;
            addr_d      = addr_q + ADDR_W'(1);
            if (!bus.frame_end) begin
              tx_data_d = DUMMY;
              tx_load_d = 1'b1;
            end
          end
        end
        ST_RD_CAP: begin
          if (!bus.frame_end) begin
            tx_data_d = bus.reg_rdata;
            addr_d    = addr_q + ADDR_W'(1);
          end
        end
        ST_RD: begin
          if (bus.rx_valid && !bus.frame_end) reg_addr_d = addr_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_data   = rd_load ? bus.reg_rdata : tx_data_q;
  assign bus.tx_load   = tx_load_q | rd_load;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = (state_q == ST_RD_REQ);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_ctrl
// Directed bench for spi_cmd_ctrl. Inputs change and outputs are sampled on
// the falling edge; a small register-file model answers reads one cycle after
// reg_re, and a write monitor matches every reg_we against exp_q.
// ---------------------------------------------------------------------------
module tb_spi_cmd_ctrl;
  import spi_cmd_pkg::*;

  logic   clk;
  logic   rst;
  state_e state;
  int     checks = 0;
  int     errors = 0;

  logic [7:0]  mem [128];
  logic [14:0] exp_q [$];   // {addr[6:0], data[7:0]} of expected writes

  spi_cmd_ctrl_if #(.ADDR_W(7)) bus ();

  spi_cmd_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: read data valid the cycle after reg_re
  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (bus.reg_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {17'd0, bus.reg_addr, bus.reg_wdata}, 32'h7FFF_FFFF);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("we_addr_data", {17'd0, bus.reg_addr, bus.reg_wdata}, {17'd0, e});
      end
    end
    if (bus.reg_we || bus.reg_re)
      check("strobe_excl", {30'd0, bus.reg_we, bus.reg_re} == 2'b11, 32'd0);
  end

  // Driver tasks (all called at a falling edge, return at the next one)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_frame_start(input logic [7:0] st);
    bus.status      = st;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic do_frame_end();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[5] = 8'h33;
    mem[6] = 8'h44;
    mem[7] = 8'h77;

    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.status      = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_state",   32'(state), 32'(ST_IDLE));
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_strobes", {28'd0, bus.tx_load, bus.reg_we, bus.reg_re, bus.busy}, 32'd0);
    check("rst_addr",    32'(bus.reg_addr), 32'd0);
    check("rst_wdata",   32'(bus.reg_wdata), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    tick();

    // rx_valid ignored in IDLE
    send_byte(8'h12);
    check("idle_ignore", {29'd0, bus.tx_load, bus.reg_we, bus.busy}, 32'd0);

    // Frame start loads status
    do_frame_start(8'h5A);
    check("fs_tx_load", 32'(bus.tx_load), 32'd1);
    check("fs_tx_data", 32'(bus.tx_data), 32'h5A);
    check("fs_busy",    32'(bus.busy), 32'd1);
    check("fs_strobes", {30'd0, bus.reg_we, bus.reg_re}, 32'd0);
    check("fs_state",   32'(state), 32'(ST_CMD));
    tick();
    check("fs_load_pulse", 32'(bus.tx_load), 32'd0);

    // Write frame: cmd 0x10, data AA, BB
    send_byte(8'h10);
    check("wcmd_state",   32'(state), 32'(ST_WR));
    check("wcmd_tx_load", 32'(bus.tx_load), 32'd1);
    check("wcmd_tx_data", 32'(bus.tx_data), 32'h00);
    tick();
    exp_q.push_back({7'h10, 8'hAA});
    send_byte(8'hAA);
    check("w0_we",    32'(bus.reg_we), 32'd1);
    check("w0_addr",  32'(bus.reg_addr), 32'h10);
    check("w0_wdata", 32'(bus.reg_wdata), 32'hAA);
    check("w0_load",  {23'd0, bus.tx_load, bus.tx_data}, {23'd0, 1'b1, 8'h00});
    tick();
    exp_q.push_back({7'h11, 8'hBB});
    send_byte(8'hBB);
    check("w1_addr",  32'(bus.reg_addr), 32'h11);
    check("w1_wdata", 32'(bus.reg_wdata), 32'hBB);
    tick();
    do_frame_end();
    check("wend_state", 32'(state), 32'(ST_IDLE));
    check("wend_busy",  32'(bus.busy), 32'd0);

    // Read frame: cmd 0x85, then two dummies
    do_frame_start(8'h5A);
    tick();
    send_byte(8'h85);
    check("r0_re",     32'(bus.reg_re), 32'd1);
    check("r0_addr",   32'(bus.reg_addr), 32'h05);
    check("r0_noload", 32'(bus.tx_load), 32'd0);
    tick();
    check("r0_load",   32'(bus.tx_load), 32'd1);
    check("r0_data",   32'(bus.tx_data), 32'h33);
    check("r0_re_off", 32'(bus.reg_re), 32'd0);
    tick();
    check("r0_hold",   {23'd0, bus.tx_load, bus.tx_data}, {23'd0, 1'b0, 8'h33});
    check("r0_state",  32'(state), 32'(ST_RD));
    send_byte(8'hFF);
    check("r1_re",     {23'd0, bus.reg_re, 1'b0, bus.reg_addr}, {23'd0, 1'b1, 8'h06});
    tick();
    check("r1_data",   {23'd0, bus.tx_load, bus.tx_data}, {23'd0, 1'b1, 8'h44});
    tick();
    send_byte(8'hFF);
    check("r2_addr",   32'(bus.reg_addr), 32'h07);
    tick();
    check("r2_data",   32'(bus.tx_data), 32'h77);
    do_frame_end();
    check("rend_busy", 32'(bus.busy), 32'd0);

    // Address wrap on write
    do_frame_start(8'h00);
    send_byte(8'h7F);
    exp_q.push_back({7'h7F, 8'h11});
    send_byte(8'h11);
    check("wrap0_addr", 32'(bus.reg_addr), 32'h7F);
    exp_q.push_back({7'h00, 8'h22});
    send_byte(8'h22);
    check("wrap1_addr", 32'(bus.reg_addr), 32'h00);
    check("wrap1_data", 32'(bus.reg_wdata), 32'h22);
    do_frame_end();

    // Overrun: extra byte one clock after a read command
    do_frame_start(8'h00);
    send_byte(8'h86);
    check("ov_state",   32'(state), 32'(ST_RD_REQ));
    send_byte(8'h99);
    check("ov_flag",    32'(bus.overrun), 32'd1);
    check("ov_data",    {23'd0, bus.tx_load, bus.tx_data}, {23'd0, 1'b1, 8'h44});
    tick();
    do_frame_end();
    check("ov_sticky",  32'(bus.overrun), 32'd1);
    do_frame_start(8'h3C);
    check("ov_cleared", 32'(bus.overrun), 32'd0);
    tick();

    // frame_end while in RD_CAP aborts the fetch
    send_byte(8'h85);
    tick();
    check("ab_state",  32'(state), 32'(ST_RD_CAP));
    bus.frame_end = 1'b1;
    #1;
    check("ab_noload", 32'(bus.tx_load), 32'd0);
    tick();
    bus.frame_end = 1'b0;
    check("ab_idle",   {28'd0, state == ST_IDLE, bus.busy, bus.tx_load, bus.reg_re}, {28'd0, 4'b1000});
    tick();
    check("ab_data",   {23'd0, bus.tx_load, bus.tx_data}, {23'd0, 1'b0, 8'h3C});

    // Reset in the middle of a write frame
    do_frame_start(8'h01);
    send_byte(8'h20);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    rst          = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    check("rw_state",   32'(state), 32'(ST_IDLE));
    check("rw_strobes", {28'd0, bus.tx_load, bus.reg_we, bus.reg_re, bus.busy}, 32'd0);
    check("rw_addr",    {15'd0, bus.reg_addr, bus.reg_wdata, 2'b00}, 32'd0);
    rst = 1'b0;
    tick();
    check("rw_after",   {29'd0, bus.tx_load, bus.reg_we, bus.busy}, 32'd0);
    tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer behind the SPI slave byte engine.
- Decodes the first byte of each SSEL-framed transaction as a command: bit7 = R/W (1 = read), bits6:0 = start address.
- Turns the following bytes into register-file write or read strobes, with address auto-increment.
- Supplies the next MISO byte to the byte engine.
- Sits between the SPI byte engine and the CPLD register file / CoCo bus side.

Parameters:
- ADDR_W, 7, register address width; command address field is rx_data[ADDR_W-1:0] (ADDR_W ≤ 7).
- DUMMY, 8'h00, byte returned on MISO during write frames.

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-clk pulse, SSEL falling edge (already synchronised).
- frame_end  in  1  one-clk pulse, SSEL rising edge.
- rx_valid  in  1  one-clk pulse, a full MOSI byte has been received.
- rx_data  in  8  received byte, valid while rx_valid = 1.
- status  in  8  status byte, sampled at frame_start.
- tx_data  out  8  next byte for MISO shift-out.
- tx_load  out  1  one-clk pulse, tx_data has been updated.
- reg_addr  out  ADDR_W  register file address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-clk write strobe.
- reg_re  out  1  one-clk read strobe.
- reg_rdata  in  8  read data, valid on the cycle after reg_re.
- busy  out  1  high from frame_start until frame_end is processed.
- overrun  out  1  sticky error flag, cleared at frame_start.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: state = IDLE, tx_data = 8'h00, tx_load = 0, reg_we = 0, reg_re = 0, reg_addr = 0, reg_wdata = 0, busy = 0, overrun = 0.
- State machine states: IDLE, CMD, WR, RD_REQ, RD_CAP, RD.
- IDLE:
  - rx_valid is ignored.
  - On frame_start: state → CMD; tx_data ← status; tx_load pulses next cycle; busy ← 1; overrun ← 0.
- CMD + rx_valid (cycle T):
  - Latch the address and R/W bit.
  - Write command → WR; tx_data ← DUMMY; tx_load at T+1.
  - Read command → RD_REQ.
- RD_REQ:
  - reg_re = 1 with reg_addr = addr at T+1.
  - → RD_CAP.
- RD_CAP:
  - At T+2, tx_data ← reg_rdata and tx_load = 1 (tx_load is high exactly 2 clk after rx_valid).
  - addr ← addr+1; → RD.
- RD + rx_valid: the byte is a dummy; its content is ignored. Prefetch the next address via RD_REQ → RD_CAP, same timing as above.
- WR + rx_valid at T:
  - At T+1: reg_we = 1, reg_addr = addr, reg_wdata = rx_data.
  - tx_data ← DUMMY, tx_load at T+1.
  - addr ← addr+1.
- Address wrap: addr wraps modulo 2^ADDR_W (all-ones → 0); there is no error on wrap.
- rx_valid while in RD_REQ/RD_CAP: overrun ← 1; the byte is dropped; the fetch completes normally.
- frame_start coincident with rx_valid: frame_start wins and rx_valid is ignored. frame_start in any non-IDLE state restarts at CMD.
- frame_end:
  - From any state → IDLE next cycle; busy ← 0.
  - Coincident with rx_valid in WR: the write is still committed (reg_we at T+1), then IDLE.
  - During RD_REQ/RD_CAP: the fetch is aborted; no tx_load is issued.
- Strobe exclusivity: reg_we and reg_re are never high together. tx_load is never high in IDLE except in the cycle after frame_start.
- Reset mid-frame: all outputs return to their reset values immediately; no strobe completes.

Decomposition:
- Package spi_cmd_pkg:
  - state enum;
  - CMD_RD_BIT = 7;
  - DUMMY default;
  - ADDR_W default.
- Single module; no sub-module. The byte engine and register file live outside.

Test Plan:
- Reset then frame_start with status = 8'h5A → tx_load one clk later with tx_data = 8'h5A; busy = 1; all strobes 0.
- Write frame: cmd 8'h10, then bytes 8'hAA, 8'hBB → reg_we at addr 0x10 = 8'hAA and addr 0x11 = 8'hBB, each 1 clk after rx_valid; tx_data = 8'h00 after each byte.
- Read frame: cmd 8'h85 with reg[5] = 8'h33 and reg[6] = 8'h44, then two dummy bytes → reg_re at addr 5, tx_data = 8'h33 with tx_load 2 clk after the cmd rx_valid; then addr 6 → 8'h44.
- Wrap: write cmd 8'h7F, then two bytes → writes land at 0x7F then 0x00.
- rx_valid injected 1 clk after a read-cmd rx_valid → overrun = 1, the fetch still returns correct data; the next frame_start clears overrun.
- frame_end in RD_CAP, and a separate assertion of rst mid-WR → no tx_load / no reg_we after the event; state is IDLE; busy = 0.
